// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the overflow_o signal.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  // Operand side: start/ready handshake
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             borrow_i;
  logic             ready_o;
  // Result side: valid/ready handshake
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow_o;
`endif

  // Producer of operands and consumer of results
  modport master (
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  overflow_o,
`endif
    output start_i, a_i, b_i, borrow_i, ready_i,
    input  ready_o, valid_o, diff_o, borrow_o
  );

  // The subtractor itself
  modport slave (
`ifdef SERIAL_SUB_OVERFLOW_EN
    output overflow_o,
`endif
    input  start_i, a_i, b_i, borrow_i, ready_i,
    output ready_o, valid_o, diff_o, borrow_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: diff = a - b - borrow_in over WIDTH cycles
// with one full-subtractor cell and a borrow flip-flop.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds signed-overflow detection.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_br;

  logic             w_accept;
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;

  assign w_accept = bus.start_i & (r_state == S_IDLE);

  // Full-subtractor cell on the current LSBs
  assign w_x       = r_a_sh[0];
  assign w_y       = r_b_sh[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned
    // (which would infer a latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i)          w_next = S_BUSY;
      S_BUSY:  if (r_cnt == LAST_BIT)    w_next = S_DONE;
      S_DONE:  if (bus.ready_i)          w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register
  always_comb begin
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    case (r_state)
      S_IDLE:  bus.ready_o = 1'b1;
      S_DONE:  bus.valid_o = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, bit-serial shifting and bit counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= bus.a_i;
      r_b_sh <= bus.b_i;
      r_br   <= bus.borrow_i;
      r_cnt  <= '0;
    end else if (r_state == S_BUSY) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_br   <= w_br_next;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Result and borrow hold their last values outside DONE
  assign bus.diff_o   = r_res;
  assign bus.borrow_o = r_br;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_sa;
  logic r_sb;

  // Operand sign capture for signed-overflow detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (w_accept) begin
      r_sa <= bus.a_i[WIDTH-1];
      r_sb <= bus.b_i[WIDTH-1];
    end
  end

  // Overflow: operand signs differ and the result sign differs from the minuend
  assign bus.overflow_o = (r_state == S_DONE) & (r_sa != r_sb) & (r_res[WIDTH-1] != r_sa);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised bench for serial_subtractor at WIDTH=8.
// Overflow checks are compiled in when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int TIMEOUT = 100;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus_if ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one operation and wait for valid_o; returns latency in cycles
  // (TIMEOUT+ on expiry). Leaves the block in DONE with ready_i low.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, output int lat);
    int w = 0;
    while (!bus_if.ready_o && w < TIMEOUT) begin
      tick();
      w++;
    end
    bus_if.start_i  = 1'b1;
    bus_if.a_i      = a;
    bus_if.b_i      = b;
    bus_if.borrow_i = bi;
    tick();
    bus_if.start_i  = 1'b0;
    bus_if.a_i      = ~a;
    bus_if.b_i      = ~b;
    bus_if.borrow_i = ~bi;
    lat = 0;
    while (!bus_if.valid_o && lat <= TIMEOUT) begin
      tick();
      lat++;
    end
  endtask

  // Complete the result handshake with a one-cycle ready_i pulse
  task automatic drain();
    bus_if.ready_i = 1'b1;
    tick();
    bus_if.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i          = 1'b1;
    bus_if.start_i = 1'b1;
    bus_if.a_i     = 8'hAA;
    bus_if.b_i     = 8'h11;
    tick();
    tick();
    n_checks++;
    if (bus_if.ready_o !== 1'b1 || bus_if.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: ready_o=%b valid_o=%b, required ready_o=1 valid_o=0",
               bus_if.ready_o, bus_if.valid_o);
    end
    n_checks++;
    if (bus_if.diff_o !== 8'h00 || bus_if.borrow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: diff_o=%h borrow_o=%b, required 00/0",
               bus_if.diff_o, bus_if.borrow_o);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_checks++;
    if (bus_if.overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overflow: overflow_o=%b, required 0", bus_if.overflow_o);
    end
`endif
    bus_if.start_i = 1'b0;
    rst_i          = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    launch(8'h05, 8'h03, 1'b0, lat);
    n_checks++;
    if (lat !== WIDTH) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", lat, WIDTH);
    end
    n_checks++;
    if (bus_if.diff_o !== 8'h02 || bus_if.borrow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: diff_o=%h borrow_o=%b, required 02/0",
               bus_if.diff_o, bus_if.borrow_o);
    end
    n_checks++;
    if (bus_if.ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_in_done: ready_o=%b, required 0", bus_if.ready_o);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_checks++;
    if (bus_if.overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_overflow: overflow_o=%b, required 0", bus_if.overflow_o);
    end
`endif
    drain();
    n_checks++;
    if (bus_if.ready_o !== 1'b1 || bus_if.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return_idle: ready_o=%b valid_o=%b, required 1/0",
               bus_if.ready_o, bus_if.valid_o);
    end
  endtask

  task automatic test_negative();
    int lat;
    launch(8'h03, 8'h05, 1'b0, lat);
    n_checks++;
    if (lat !== WIDTH || bus_if.diff_o !== 8'hFE || bus_if.borrow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL negative_result: lat=%0d diff_o=%h borrow_o=%b, required %0d/FE/1",
               lat, bus_if.diff_o, bus_if.borrow_o, WIDTH);
    end
    drain();
    launch(8'h00, 8'h00, 1'b1, lat);
    n_checks++;
    if (lat !== WIDTH || bus_if.diff_o !== 8'hFF || bus_if.borrow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL chained_borrow: lat=%0d diff_o=%h borrow_o=%b, required %0d/FF/1",
               lat, bus_if.diff_o, bus_if.borrow_o, WIDTH);
    end
    drain();
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow();
    int lat;
    launch(8'h80, 8'h01, 1'b0, lat);
    n_checks++;
    if (bus_if.diff_o !== 8'h7F || bus_if.borrow_o !== 1'b0 || bus_if.overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_neg: diff_o=%h borrow_o=%b overflow_o=%b, required 7F/0/1",
               bus_if.diff_o, bus_if.borrow_o, bus_if.overflow_o);
    end
    drain();
    n_checks++;
    if (bus_if.overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_outside_done: overflow_o=%b, required 0", bus_if.overflow_o);
    end
    launch(8'h7F, 8'hFF, 1'b0, lat);
    n_checks++;
    if (bus_if.diff_o !== 8'h80 || bus_if.borrow_o !== 1'b1 || bus_if.overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pos: diff_o=%h borrow_o=%b overflow_o=%b, required 80/1/1",
               bus_if.diff_o, bus_if.borrow_o, bus_if.overflow_o);
    end
    drain();
  endtask
`endif

  task automatic test_back_pressure();
    int lat;
    int bad = 0;
    launch(8'h40, 8'h21, 1'b0, lat);
    // 0x40 - 0x21 = 0x1F, no borrow
    for (int i = 0; i < 5; i++) begin
      bus_if.start_i = ~bus_if.start_i;
      bus_if.a_i     = 8'h13 * (i + 1);
      bus_if.b_i     = 8'hC5 ^ bus_if.a_i;
      tick();
      if (bus_if.valid_o !== 1'b1 || bus_if.ready_o !== 1'b0 ||
          bus_if.diff_o !== 8'h1F || bus_if.borrow_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL back_pressure_hold: %0d unstable cycles, last valid_o=%b ready_o=%b diff_o=%h, required 1/0/1F",
               bad, bus_if.valid_o, bus_if.ready_o, bus_if.diff_o);
    end
    // start_i high on the DONE-exit edge must be ignored
    bus_if.start_i = 1'b1;
    bus_if.a_i     = 8'h09;
    bus_if.b_i     = 8'h01;
    drain();
    n_checks++;
    if (bus_if.ready_o !== 1'b1 || bus_if.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL back_pressure_exit: ready_o=%b valid_o=%b, required 1/0",
               bus_if.ready_o, bus_if.valid_o);
    end
    bus_if.start_i = 1'b0;
    launch(8'h10, 8'h01, 1'b0, lat);
    n_checks++;
    if (lat !== WIDTH || bus_if.diff_o !== 8'h0F || bus_if.borrow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL back_pressure_next: lat=%0d diff_o=%h borrow_o=%b, required %0d/0F/0",
               lat, bus_if.diff_o, bus_if.borrow_o, WIDTH);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    bus_if.start_i  = 1'b1;
    bus_if.a_i      = 8'h55;
    bus_if.b_i      = 8'h0F;
    bus_if.borrow_i = 1'b0;
    tick();
    bus_if.start_i = 1'b0;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if (bus_if.ready_o !== 1'b1 || bus_if.valid_o !== 1'b0 ||
        bus_if.diff_o !== 8'h00 || bus_if.borrow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: ready_o=%b valid_o=%b diff_o=%h borrow_o=%b, required 1/0/00/0",
               bus_if.ready_o, bus_if.valid_o, bus_if.diff_o, bus_if.borrow_o);
    end
    launch(8'h55, 8'h0F, 1'b0, lat);
    n_checks++;
    if (lat !== WIDTH || bus_if.diff_o !== 8'h46 || bus_if.borrow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: lat=%0d diff_o=%h borrow_o=%b, required %0d/46/0",
               lat, bus_if.diff_o, bus_if.borrow_o, WIDTH);
    end
    drain();
  endtask

  task automatic test_random();
    int lat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH:0]   exp;
    for (int i = 0; i < 1000; i++) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      bi  = 1'($urandom);
      exp = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
      launch(a, b, bi, lat);
      n_checks++;
      if (lat !== WIDTH || {bus_if.borrow_o, bus_if.diff_o} !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: %h-%h-%b lat=%0d got %h, required %h",
                 i, a, b, bi, lat, {bus_if.borrow_o, bus_if.diff_o}, exp);
      end
      for (int s = $urandom_range(0, 3); s > 0; s--) tick();
      drain();
    end
  endtask

  initial begin
    bus_if.start_i  = 1'b0;
    bus_if.a_i      = '0;
    bus_if.b_i      = '0;
    bus_if.borrow_i = 1'b0;
    bus_if.ready_i  = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_negative();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor computing `a - b - borrow_in` over `WIDTH` clock cycles, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the ripple full-adder datapath. It is used where area matters more than latency, for example in the multi-cycle ALU and divider paths. Operands enter through a start/ready handshake, and the result leaves through a valid/ready handshake.

## Interface
- `WIDTH`, default 32: operand and result width in bits; minimum 2.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  operand request; accepted on an edge where `start_i & ready_o`.
- `a_i`  in  WIDTH  minuend; sampled on acceptance.
- `b_i`  in  WIDTH  subtrahend; sampled on acceptance.
- `borrow_i`  in  1  borrow-in; sampled on acceptance.
- `ready_o`  out  1  block is IDLE and can accept operands.
- `valid_o`  out  1  result available.
- `ready_i`  in  1  consumer takes the result; the handshake completes on an edge where `valid_o & ready_i`.
- `diff_o`  out  WIDTH  result `(a - b - borrow_in) mod 2^WIDTH`.
- `borrow_o`  out  1  borrow out of the MSB; 1 means the unsigned result is negative.
- `overflow_o`  out  1  signed overflow; present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- FSM states are IDLE, BUSY and DONE, with one bit counter `cnt` of width `$clog2(WIDTH+1)`.
- IDLE:
  - `ready_o=1`.
  - On acceptance, latch `a_i`, `b_i` and `borrow_i` into the shift registers `a_sh` and `b_sh` and the borrow register `br`.
  - Set `cnt=0` and go to BUSY.
- BUSY: each edge, with `x=a_sh[0]`, `y=b_sh[0]`:
  - Compute `d = x^y^br` and `br <= (~x&y) | (~x&br) | (y&br)`.
  - Shift `a_sh` and `b_sh` right by 1.
  - Shift `d` into the MSB of the result register (right shift).
  - Increment `cnt`.
  - On the edge where `cnt` reaches `WIDTH`, go to DONE.
- DONE:
  - `valid_o=1`.
  - `diff_o` equals the result register and `borrow_o=br`.
  - Outputs are held stable until `ready_i`.
  - On `valid_o & ready_i`, go to IDLE.
- `ready_o` is high only in IDLE. `start_i` is ignored in BUSY and DONE, including on the DONE-exit edge.
- `diff_o` and `borrow_o` keep their last values after DONE exits, but are meaningful only while `valid_o=1`.
- Operand inputs may change freely after acceptance; they are not re-sampled.

## Timing
- Reset values: state IDLE, `ready_o=1`, `valid_o=0`, `diff_o=0`, `borrow_o=0`, `overflow_o=0`, `cnt=0`.
- `ready_o` and `valid_o` are decoded directly from the state register, with no combinational path from any input.
- Latency: operands accepted on edge E0 give `valid_o=1` after edge E_WIDTH, i.e. exactly `WIDTH` cycles later.
- Throughput: one operation per `WIDTH+2` cycles with `ready_i` held high (IDLE accept, WIDTH BUSY cycles, one DONE cycle).
- Counter boundary:
  - The last bit is processed on the edge with `cnt=WIDTH-1`.
  - `cnt` never exceeds `WIDTH`.
  - `cnt` is cleared on acceptance.
- Back-pressure: DONE persists indefinitely with `ready_i=0`, and outputs do not change.
- Reset in any state (mid-BUSY or DONE) aborts the operation on that edge:
  - All registers return to their reset values.
  - The partial result is discarded.
  - `ready_o=1` in the next cycle.
- `rst_i` has priority over `start_i` and `ready_i` on the same edge.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN` defined:
  - On acceptance, latch `sa=a_i[WIDTH-1]` and `sb=b_i[WIDTH-1]`.
  - In DONE, drive `overflow_o = (sa != sb) & (diff_o[WIDTH-1] != sa)`.
  - `overflow_o` is 0 outside DONE and after reset.
- `SERIAL_SUB_OVERFLOW_EN` undefined:
  - Port `overflow_o` and its registers do not exist.
  - All other behaviour is identical.

## Test plan
All scenarios use `WIDTH=8`.
- Basic: `a=0x05`, `b=0x03`, `borrow_i=0` -> `valid_o` rises exactly 8 cycles after acceptance with `diff_o=0x02` and `borrow_o=0`; `overflow_o=0` when enabled.
- Negative result: `a=0x03`, `b=0x05`, `borrow_i=0` -> `diff_o=0xFE`, `borrow_o=1`. Chained borrow: `a=0x00`, `b=0x00`, `borrow_i=1` -> `diff_o=0xFF`, `borrow_o=1`.
- Signed overflow (macro on): `a=0x80`, `b=0x01` -> `diff_o=0x7F`, `borrow_o=0`, `overflow_o=1`. Also `a=0x7F`, `b=0xFF` -> `diff_o=0x80`, `borrow_o=1`, `overflow_o=1`.
- Back-pressure: hold `ready_i=0` for 5 cycles in DONE while toggling `start_i` and the operands -> `valid_o`, `diff_o` and `ready_o=0` are stable. The `ready_i` pulse returns the block to IDLE, and the next `start_i` is accepted.
- Reset mid-operation: assert `rst_i` 4 cycles after accepting `0x55 - 0x0F` -> `ready_o=1`, `valid_o=0`, `diff_o=0` next cycle. A following `0x55 - 0x0F` yields `diff_o=0x46` and `borrow_o=0`.
- Randomised: 1000 random operand/borrow triples with random `ready_i` stalls -> every result matches `{borrow_o, diff_o} == ({1'b0,a} - {1'b0,b} - borrow_i)` in 9-bit two's complement.
